// File: rtl/rnd_arbiter.sv
// ============================================================================
// Module      : rnd_arbiter
// Description : Round-robin arbiter sharing one 32-bit Galois LFSR among NREQ
//               requesters; each grant carries a distinct LFSR state.
//               Optional reseed port enabled by RND_ARBITER_RESEED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rnd_arbiter #(
    parameter int          NREQ       = 4,
    parameter logic [31:0] POLY       = 32'h80200003,
    parameter logic [31:0] SEED       = 32'hbed4dead,
    parameter int          WARMUP_CYC = 16
) (
    input  logic            clk,
    input  logic            I_reset,
    input  logic [NREQ-1:0] I_req,
`ifdef RND_ARBITER_RESEED_EN
    input  logic            I_seed_vld,
    input  logic [31:0]     I_seed,
`endif
    output logic [NREQ-1:0] O_gnt,
    output logic [31:0]     O_rnd,
    output logic            O_ready
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CNT_W = $clog2(WARMUP_CYC + 1);

    typedef enum logic [0:0] {
        S_WARM = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [31:0]          r_lfsr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [NREQ-1:0]      r_gnt;
    logic [31:0]          r_rnd;
    logic                 r_ready;

    logic [31:0]          w_lfsr_next;
    logic [NREQ-1:0]      w_elig;
    logic                 w_found;
    logic [c_PTR_W-1:0]   w_win;

    assign w_lfsr_next = {r_lfsr[30:0] ^ (POLY[31:1] & {31{r_lfsr[31]}}), r_lfsr[31]};
    assign w_elig      = I_req & ~r_gnt;

    // Scan from the slot after the last winner, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx = (int'(r_ptr) + i) % NREQ;
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_win   = c_PTR_W'(idx);
            end
        end
    end

`ifdef RND_ARBITER_RESEED_EN
    logic [31:0] w_reseed;
    assign w_reseed = r_lfsr ^ I_seed;
`endif

    always_ff @(posedge clk) begin
        if (I_reset) begin
            r_lfsr  <= SEED;
            r_state <= S_WARM;
            r_cnt   <= '0;
            r_ptr   <= c_PTR_W'(NREQ - 1);
            r_gnt   <= '0;
            r_rnd   <= '0;
            r_ready <= 1'b0;
`ifdef RND_ARBITER_RESEED_EN
        end else if (I_seed_vld) begin
            // All-zero is a lock-up state for the LFSR, so fall back to SEED.
            r_lfsr  <= (w_reseed == 32'h0) ? SEED : w_reseed;
            r_state <= S_WARM;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_ready <= 1'b0;
`endif
        end else begin
            r_lfsr <= w_lfsr_next;
            case (r_state)
                S_WARM: begin
                    r_gnt <= '0;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(WARMUP_CYC - 1)) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_found) begin
                        r_gnt <= NREQ'(1) << w_win;
                        r_rnd <= r_lfsr;
                        r_ptr <= w_win;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                default: begin
                    r_state <= S_WARM;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign O_gnt   = r_gnt;
    assign O_rnd   = r_rnd;
    assign O_ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_rnd_arbiter.sv
// ============================================================================
// Module      : tb_rnd_arbiter
// Description : Scoreboard bench for rnd_arbiter against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rnd_arbiter;

    localparam int          NREQ = 4;
    localparam int          WARM = 2;
    localparam logic [31:0] POLY = 32'h80200003;
    localparam logic [31:0] SEED = 32'hbed4dead;

    logic            clk = 1'b0;
    logic            I_reset = 1'b1;
    logic [NREQ-1:0] I_req = '0;
    logic [NREQ-1:0] O_gnt;
    logic [31:0]     O_rnd;
    logic            O_ready;
`ifdef RND_ARBITER_RESEED_EN
    logic            I_seed_vld = 1'b0;
    logic [31:0]     I_seed = '0;
`endif

    rnd_arbiter #(.NREQ(NREQ), .POLY(POLY), .SEED(SEED), .WARMUP_CYC(WARM)) dut (
        .clk(clk),
        .I_reset(I_reset),
        .I_req(I_req),
`ifdef RND_ARBITER_RESEED_EN
        .I_seed_vld(I_seed_vld),
        .I_seed(I_seed),
`endif
        .O_gnt(O_gnt),
        .O_rnd(O_rnd),
        .O_ready(O_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] gnt;
        logic [31:0]     rnd;
    } exp_t;
    exp_t sbq[$];
    bit   seen[logic [31:0]];

    // Behavioural model state
    logic [31:0]     m_s = SEED;
    logic [NREQ-1:0] m_gnt = '0;
    logic [31:0]     m_rnd = '0;
    logic            m_ready = 1'b0;
    int              m_steps = 0;
    int              m_last = NREQ - 1;
    int              cyc = 0;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = s << 1;
        if (s[31]) n = n ^ POLY;
        n[0] = s[31];
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (I_reset) begin
            m_s = SEED; m_gnt = '0; m_rnd = '0; m_ready = 1'b0;
            m_steps = 0; m_last = NREQ - 1;
            seen.delete();
`ifdef RND_ARBITER_RESEED_EN
        end else if (I_seed_vld) begin
            m_s = ((m_s ^ I_seed) == 32'h0) ? SEED : (m_s ^ I_seed);
            m_gnt = '0; m_ready = 1'b0; m_steps = 0;
            seen.delete();
`endif
        end else begin
            if (!m_ready) begin
                m_gnt = '0;
                m_steps++;
                if (m_steps >= WARM) m_ready = 1'b1;
            end else begin
                logic [NREQ-1:0] avail;
                int              w;
                avail = I_req & ~m_gnt;
                w = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (w < 0 && avail[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
                if (w >= 0) begin
                    m_gnt = '0;
                    m_gnt[w] = 1'b1;
                    m_rnd = m_s;
                    m_last = w;
                    sbq.push_back('{cyc, m_gnt, m_s});
                end else begin
                    m_gnt = '0;
                end
            end
            m_s = lfsr_step(m_s);
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("ready", 32'(O_ready), 32'(m_ready));
            if (O_gnt !== '0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_gnt", 32'(O_gnt), 32'h0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
                    chk("gnt", 32'(O_gnt), 32'(e.gnt));
                    chk("rnd", O_rnd, e.rnd);
                    chk("rnd_distinct", 32'(seen.exists(O_rnd)), 32'h0);
                    seen[O_rnd] = 1'b1;
                end
            end else begin
                if (sbq.size() != 0 && sbq[0].cyc == cyc) begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("missed_gnt", 32'(O_gnt), 32'(e.gnt));
                end
                chk("rnd_hold", O_rnd, m_rnd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        repeat (3) tick();

        // Warm-up with a single held request
        I_reset = 1'b0;
        I_req   = 4'b0001;
        tick();
        chk("lfsr_step1", dut.r_lfsr, 32'hfd89bd59);
        chk("warm_no_gnt", 32'(O_gnt), 32'h0);
        tick();
        chk("ready_after_warm", 32'(O_ready), 32'h1);
        tick();
        chk("first_gnt", 32'(O_gnt), 32'h1);

        // All requesting: rotating grants
        I_req = 4'b1111;
        repeat (12) tick();

        // Lone requester alternates, then a new one joins
        I_req = 4'b0100;
        repeat (6) tick();
        I_req = 4'b0101;
        repeat (4) tick();

        // Reset in the cycle where requester 1 holds the grant
        I_req = 4'b1111;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (O_gnt === 4'b0010) found = 1'b1;
            else tick();
        end
        chk("wait_gnt1", 32'(found), 32'h1);
        I_reset = 1'b1;
        tick();
        I_reset = 1'b0;
        chk("reset_gnt", 32'(O_gnt), 32'h0);
        chk("reset_ready", 32'(O_ready), 32'h0);
        repeat (8) tick();

`ifdef RND_ARBITER_RESEED_EN
        // Seed that cancels the state exercises the zero guard
        I_seed     = m_s;
        I_seed_vld = 1'b1;
        tick();
        I_seed_vld = 1'b0;
        chk("reseed_zero_guard", dut.r_lfsr, SEED);
        repeat (6) tick();
        for (int i = 0; i < 40; i++) begin
            I_req      = NREQ'($urandom);
            I_seed     = $urandom;
            I_seed_vld = ($urandom_range(0, 9) == 0);
            tick();
        end
        I_seed_vld = 1'b0;
`endif

        // Randomized requests with occasional resets
        for (int i = 0; i < 400; i++) begin
            I_req   = NREQ'($urandom);
            I_reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        I_reset = 1'b0;
        I_req   = '0;
        repeat (5) tick();
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
